// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder and the iterative mul/div engine:
// ALU operation codes, main-control classes, funct/opcode values and FSM states.
package alu_ctrl_pkg;

    // ALU operation encodings driven on oprd
    localparam logic [3:0] OPRD_ADD = 4'd0;
    localparam logic [3:0] OPRD_SUB = 4'd1;
    localparam logic [3:0] OPRD_AND = 4'd2;
    localparam logic [3:0] OPRD_OR  = 4'd3;
    localparam logic [3:0] OPRD_XOR = 4'd4;
    localparam logic [3:0] OPRD_NOR = 4'd5;
    localparam logic [3:0] OPRD_BEQ = 4'd6;
    localparam logic [3:0] OPRD_BNE = 4'd7;
    localparam logic [3:0] OPRD_SLL = 4'd8;
    localparam logic [3:0] OPRD_SRL = 4'd9;
    localparam logic [3:0] OPRD_SRA = 4'd10;
    localparam logic [3:0] OPRD_LUI = 4'd11;

    // Main-control instruction classes
    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    // R-type funct values
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // Opcode values
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_SLTIU = 6'b001011;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;

    // Mul/div engine mode: bit 1 selects divide, bit 0 selects unsigned
    localparam logic [1:0] MD_MODE_MULT  = 2'b00;
    localparam logic [1:0] MD_MODE_MULTU = 2'b01;
    localparam logic [1:0] MD_MODE_DIV   = 2'b10;
    localparam logic [1:0] MD_MODE_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // True for the four funct codes that launch the iterative engine
    function automatic logic is_md_funct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

    // True for the four funct codes that read or write HI/LO
    function automatic logic is_hilo_funct(input logic [5:0] fn);
        return (fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) || (fn == FN_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, with sign correction applied in a final step.
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    md_state_e        state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    // Multiply: {partial upper, multiplier}. Divide: {remainder, quotient}.
    logic [W2-1:0]    acc_q,    acc_d;
    // Multiplicand or divisor magnitude
    logic [WIDTH-1:0] opb_q,    opb_d;
    // Raw dividend, returned in hi on divide by zero
    logic [WIDTH-1:0] a_raw_q,  a_raw_d;
    logic [1:0]       mode_q,   mode_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;

    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH:0]   add_sum_s, rem_shift_s, rem_diff_s;
    logic [W2-1:0]    mul_next_s, div_next_s, prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;

    // Operand magnitudes, single iteration step and sign-corrected results
    always_comb begin
        a_neg_s = ~mode[0] & a[WIDTH-1];
        b_neg_s = ~mode[0] & b[WIDTH-1];
        a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - a) : a;
        b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - b) : b;

        add_sum_s  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {add_sum_s, acc_q[WIDTH-1:1]};

        rem_shift_s = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff_s  = rem_shift_s - {1'b0, opb_q};
        if (rem_diff_s[WIDTH]) begin
            div_next_s = {rem_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {rem_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end

        prod_s = neg_lo_q ? ({W2{1'b0}} - acc_q) : acc_q;
        quo_s  = neg_lo_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_s  = neg_hi_q ? ({WIDTH{1'b0}} - acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];
    end

    // Next-state and next-register computation for the IDLE/RUN/FIX sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        a_raw_d  = a_raw_q;
        mode_d   = mode_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d  = MD_RUN;
                    cnt_d    = CW'(WIDTH - 1);
                    acc_d    = {{WIDTH{1'b0}}, a_mag_s};
                    opb_d    = b_mag_s;
                    a_raw_d  = a;
                    mode_d   = mode;
                    neg_lo_d = a_neg_s ^ b_neg_s;
                    neg_hi_d = mode[1] ? a_neg_s : (a_neg_s ^ b_neg_s);
                    busy_d   = 1'b1;
                end else begin
                    state_d  = MD_IDLE;
                end
            end
            MD_RUN: begin
                acc_d = mode_q[1] ? div_next_s : mul_next_s;
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = MD_FIX;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!mode_q[1]) begin
                    hi_d = prod_s[W2-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end else if (opb_q == {WIDTH{1'b0}}) begin
                    hi_d = a_raw_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
            end
            default: begin
                state_d = MD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MD_IDLE;
            cnt_q    <= {CW{1'b0}};
            acc_q    <= {W2{1'b0}};
            opb_q    <= {WIDTH{1'b0}};
            a_raw_q  <= {WIDTH{1'b0}};
            mode_q   <= 2'b00;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            a_raw_q  <= a_raw_d;
            mode_q   <= mode_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// ALU control decoder with HI/LO register file and an optional iterative
// multiply/divide engine. Decode is purely combinational; mul/div and HI/LO
// instructions stall while the engine is busy.
module alu_ctrl_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int MD_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [5:0]       opcode,
    input  logic             decode_en,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    output logic [3:0]       oprd,
    output logic             ifslt,
    output logic             is_unsigned,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       hilo_rd
);

    logic rtype_s;
    logic md_fn_s;
    logic hilo_fn_s;

    // ALU operation decode; unlisted encodings fall back to add with no compare flags
    always_comb begin
        oprd        = OPRD_ADD;
        ifslt       = 1'b0;
        is_unsigned = 1'b0;
        case (alu_op)
            ALU_OP_ADD: begin
                oprd = OPRD_ADD;
            end
            ALU_OP_BRANCH: begin
                if (opcode == OPC_BEQ) begin
                    oprd = OPRD_BEQ;
                end else if (opcode == OPC_BNE) begin
                    oprd = OPRD_BNE;
                end else begin
                    oprd = OPRD_ADD;
                end
            end
            ALU_OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU:  oprd = OPRD_ADD;
                    FN_SUB, FN_SUBU:  oprd = OPRD_SUB;
                    FN_AND:           oprd = OPRD_AND;
                    FN_OR:            oprd = OPRD_OR;
                    FN_XOR:           oprd = OPRD_XOR;
                    FN_NOR:           oprd = OPRD_NOR;
                    FN_SLT: begin
                        oprd  = OPRD_SUB;
                        ifslt = 1'b1;
                    end
                    FN_SLTU: begin
                        oprd        = OPRD_SUB;
                        ifslt       = 1'b1;
                        is_unsigned = 1'b1;
                    end
                    FN_SLL, FN_SLLV:  oprd = OPRD_SLL;
                    FN_SRL, FN_SRLV:  oprd = OPRD_SRL;
                    FN_SRA, FN_SRAV:  oprd = OPRD_SRA;
                    default:          oprd = OPRD_ADD;
                endcase
            end
            ALU_OP_ITYPE: begin
                case (opcode)
                    OPC_ADDI, OPC_ADDIU: oprd = OPRD_ADD;
                    OPC_ANDI:            oprd = OPRD_AND;
                    OPC_ORI:             oprd = OPRD_OR;
                    OPC_XORI:            oprd = OPRD_XOR;
                    OPC_SLTI: begin
                        oprd  = OPRD_SUB;
                        ifslt = 1'b1;
                    end
                    OPC_SLTIU: begin
                        oprd        = OPRD_SUB;
                        ifslt       = 1'b1;
                        is_unsigned = 1'b1;
                    end
                    OPC_LUI:             oprd = OPRD_LUI;
                    default:             oprd = OPRD_ADD;
                endcase
            end
            default: begin
                oprd = OPRD_ADD;
            end
        endcase
    end

    // Classify the instruction for mul/div, HI/LO moves, read-port select and stall
    always_comb begin
        rtype_s   = (alu_op == ALU_OP_RTYPE);
        md_fn_s   = is_md_funct(funct);
        hilo_fn_s = is_hilo_funct(funct);
        md_stall  = decode_en & rtype_s & (md_fn_s | hilo_fn_s) & md_busy;
        if (rtype_s && (funct == FN_MFLO)) begin
            hilo_rd = 2'b01;
        end else if (rtype_s && (funct == FN_MFHI)) begin
            hilo_rd = 2'b10;
        end else begin
            hilo_rd = 2'b00;
        end
    end

    generate
        if (MD_EN != 0) begin : g_md
            logic             eng_busy_s;
            logic             eng_done_s;
            logic [WIDTH-1:0] eng_hi_s;
            logic [WIDTH-1:0] eng_lo_s;
            logic             start_s;
            logic             mthi_wr_s;
            logic             mtlo_wr_s;
            logic [WIDTH-1:0] hi_q, hi_d;
            logic [WIDTH-1:0] lo_q, lo_d;

            muldiv_iter #(
                .WIDTH (WIDTH)
            ) u_muldiv_iter (
                .clk   (clk),
                .rst_n (rst_n),
                .start (start_s),
                .mode  (funct[1:0]),
                .a     (md_a),
                .b     (md_b),
                .busy  (eng_busy_s),
                .done  (eng_done_s),
                .hi    (eng_hi_s),
                .lo    (eng_lo_s)
            );

            // Engine launch and HI/LO writes; a move in the done cycle overrides the result
            always_comb begin
                start_s   = decode_en & rtype_s & md_fn_s & ~eng_busy_s;
                mthi_wr_s = decode_en & rtype_s & (funct == FN_MTHI) & ~eng_busy_s;
                mtlo_wr_s = decode_en & rtype_s & (funct == FN_MTLO) & ~eng_busy_s;
                if (mthi_wr_s) begin
                    hi_d = md_a;
                end else if (eng_done_s) begin
                    hi_d = eng_hi_s;
                end else begin
                    hi_d = hi_q;
                end
                if (mtlo_wr_s) begin
                    lo_d = md_a;
                end else if (eng_done_s) begin
                    lo_d = eng_lo_s;
                end else begin
                    lo_d = lo_q;
                end
            end

            // Architectural HI/LO registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hi_q <= {WIDTH{1'b0}};
                    lo_q <= {WIDTH{1'b0}};
                end else begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                end
            end

            // Fresh engine results are visible in the done cycle itself
            assign md_busy = eng_busy_s;
            assign md_done = eng_done_s;
            assign hi      = eng_done_s ? eng_hi_s : hi_q;
            assign lo      = eng_done_s ? eng_lo_s : lo_q;
        end else begin : g_no_md
            assign md_busy = 1'b0;
            assign md_done = 1'b0;
            assign hi      = {WIDTH{1'b0}};
            assign lo      = {WIDTH{1'b0}};
        end
    endgenerate

endmodule
